// File: rtl/xtea_loader_pkg.sv
// xtea_loader_pkg: shared state type and constants for the XTEA frame loader.
// The S_CSUM state exists only when XTEA_LOADER_CHECKSUM_EN is defined.
package xtea_loader_pkg;
  typedef enum logic [2:0] {
    S_SYNC,
    S_KEY,
    S_CT,
`ifdef XTEA_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_WAIT
  } state_e;
  localparam int KEY_BYTES = 16;
  localparam int CT_BYTES = 8;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic WR_SEL_KEY = 1'b0;
  localparam logic WR_SEL_CT = 1'b1;
endpackage

// File: rtl/xtea_loader_timeout.sv
// xtea_loader_timeout: idle counter that flags expiry after LIMIT-1 enabled cycles without a clear.
module xtea_loader_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(LIMIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired_o = en_i && !clr_i && cnt_q == CW'(LIMIT - 1);
  always_comb cnt_d = (clr_i || expired_o) ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/xtea_frame_loader.sv
// xtea_frame_loader: writes a framed XTEA key + ciphertext into RAM and flags the job to the processor.
// Defining XTEA_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in S_CSUM.
module xtea_frame_loader
  import xtea_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       job_ready,
  input  logic       job_ack,
  output logic       err
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic err_q, err_d, job_ready_q, job_ready_d;
  logic beat, active, expired, key_last, ct_last;
`ifdef XTEA_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign active = state_q inside {S_KEY, S_CT, S_CSUM};
`else
  assign active = state_q inside {S_KEY, S_CT};
`endif
  assign in_ready = state_q != S_WAIT;
  assign beat = in_valid && in_ready;
  assign key_last = cnt_q == 4'(KEY_BYTES - 1);
  assign ct_last = cnt_q == 4'(CT_BYTES - 1);
  assign wr_en = wr_en_q;
  assign wr_sel = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign job_ready = job_ready_q;
  assign err = err_q;
  xtea_loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr_i(beat || !active),
    .en_i(active),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_en_d = 1'b0;
    wr_sel_d = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d = 1'b0;
    // job_ready is delayed a cycle behind S_WAIT so the last RAM write has landed first
    job_ready_d = state_q == S_WAIT && !(job_ack && job_ready_q);
`ifdef XTEA_LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (beat && (state_q == S_KEY || state_q == S_CT)) begin
      wr_en_d = 1'b1;
      wr_sel_d = state_q == S_CT ? WR_SEL_CT : WR_SEL_KEY;
      wr_addr_d = cnt_q;
      wr_data_d = in_data;
`ifdef XTEA_LOADER_CHECKSUM_EN
      csum_d = csum_q ^ in_data;
`endif
    end
    case (state_q)
      S_SYNC: if (beat && in_data == SYNC_BYTE) begin
        state_d = S_KEY;
        cnt_d = '0;
`ifdef XTEA_LOADER_CHECKSUM_EN
        csum_d = '0;
`endif
      end
      S_KEY: if (beat) begin
        cnt_d = key_last ? '0 : cnt_q + 4'd1;
        state_d = key_last ? S_CT : S_KEY;
      end
      S_CT: if (beat) begin
        cnt_d = ct_last ? '0 : cnt_q + 4'd1;
`ifdef XTEA_LOADER_CHECKSUM_EN
        state_d = ct_last ? S_CSUM : S_CT;
`else
        state_d = ct_last ? S_WAIT : S_CT;
`endif
      end
`ifdef XTEA_LOADER_CHECKSUM_EN
      S_CSUM: if (beat) begin
        state_d = in_data == csum_q ? S_WAIT : S_SYNC;
        err_d = in_data != csum_q;
      end
`endif
      S_WAIT: if (job_ack && job_ready_q) state_d = S_SYNC;
      default: state_d = S_SYNC;
    endcase
    if (expired) begin
      state_d = S_SYNC;
      cnt_d = '0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SYNC;
      cnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_sel_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q <= 1'b0;
      job_ready_q <= 1'b0;
`ifdef XTEA_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_en_q <= wr_en_d;
      wr_sel_q <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q <= err_d;
      job_ready_q <= job_ready_d;
`ifdef XTEA_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule

// File: doc/xtea_frame_loader.md
# xtea_frame_loader

Upstream feeder for the PicoBlaze XTEA decryption subsystem. Accepts a byte stream carrying one framed decryption job (sync byte, 128-bit key, 64-bit ciphertext) and writes the key and ciphertext into the key and ciphertext RAMs that Pico2 reads. When the frame is complete it raises a job-ready flag toward the processor and holds it until the processor acknowledges. It then re-arms for the next frame.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1024, maximum idle clocks between bytes inside a frame before the frame is aborted (must be ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  loader can accept a byte
- in_data  in  8  input byte
- wr_en  out  1  RAM write strobe
- wr_sel  out  1  0 = key RAM, 1 = ciphertext RAM
- wr_addr  out  4  byte address (key 0–15, ciphertext 0–7)
- wr_data  out  8  write byte
- job_ready  out  1  complete frame stored, waiting for processor
- job_ack  in  1  processor acknowledge (single-cycle pulse)
- err  out  1  one-cycle pulse on frame abort

## Operation
- States: S_SYNC, S_KEY, S_CT, S_CSUM (only when the macro is defined), S_WAIT.
- A beat is transferred when in_valid && in_ready.
- in_ready is decoded from the state register only, with no combinational path from in_valid. It is 1 in S_SYNC, S_KEY, S_CT and S_CSUM, and 0 in S_WAIT.
- S_SYNC:
  - A beat equal to SYNC_BYTE moves to S_KEY with byte counter = 0.
  - Any other byte is dropped silently with no err.
- S_KEY: each beat writes key RAM at address = counter. After byte 15 the counter clears and the state moves to S_CT.
- S_CT: each beat writes ciphertext RAM at address 0–7. After byte 7 the state moves to S_WAIT, or to S_CSUM when the macro is defined.
- Byte order: RAM address = arrival order. No endian swap.
- S_WAIT: job_ready = 1. On job_ack the loader goes to S_SYNC and job_ready falls the next cycle.
- job_ack is ignored in every state other than S_WAIT.
- Timeout:
  - The idle counter runs in S_KEY, S_CT and S_CSUM, and clears on every accepted beat.
  - When it reaches TIMEOUT_CYCLES-1 the loader pulses err and returns to S_SYNC. RAM contents already written are left in place.
  - If a beat arrives on the same cycle as expiry, the beat wins: it is accepted and the counter clears.
- A SYNC_BYTE value arriving mid-frame is treated as ordinary data, not as a resync.

## Timing
- Reset values: in_ready = 1 (state S_SYNC), wr_en = 0, wr_sel = 0, wr_addr = 0, wr_data = 0, job_ready = 0, err = 0. Counters are 0.
- Reset takes effect on any cycle, including mid-frame or during S_WAIT. Writes in flight are not completed.
- wr_* outputs are registered: the write strobe appears one cycle after the accepted beat and lasts one cycle.
- Back-to-back beats produce back-to-back write strobes.
- job_ready rises on the cycle after the write strobe of the last ciphertext byte, so the RAM is already updated when the processor sees it.
- Minimum frame time: 25 accepted beats. Throughput is 1 byte per cycle.
- err is a registered pulse, asserted on the cycle after expiry or after a checksum mismatch.

## Configuration
- Macro: XTEA_LOADER_CHECKSUM_EN.
- Defined:
  - The frame carries one extra byte after the ciphertext: the XOR of the 24 key and ciphertext bytes. The sync byte is excluded.
  - The byte is consumed in S_CSUM and is not written to RAM.
  - Match → S_WAIT. Mismatch → err pulse, then S_SYNC with job_ready never asserted.
- Undefined: there is no S_CSUM state, frames are 25 bytes, and err fires only on timeout.

## Structure
- Package xtea_loader_pkg holds:
  - the state enum type
  - KEY_BYTES = 16 and CT_BYTES = 8
  - the default SYNC_BYTE
  - the WR_SEL_KEY and WR_SEL_CT constants
- The mem1/mem2 address maps in system_top use the same package.
- Natural sub-module: xtea_loader_timeout, a loadable idle counter with clear, enable and an expired output.

## Test plan
- Frame A5, key 00..0F, ciphertext C3 B9 0E B5 22 56 FE 61 → 16 key writes at addresses 0–15 and 8 ciphertext writes at 0–7 with matching data. job_ready rises one cycle after the final write and in_ready drops.
- Garbage bytes 00 FF 5A before A5 → no writes and no err. The frame that follows loads normally.
- Stall after key byte 9 for TIMEOUT_CYCLES cycles → err pulses once and the loader returns to S_SYNC. A new full frame then loads correctly.
- While job_ready is high, present in_valid with data → in_ready stays 0 and there are no writes. job_ack → job_ready drops the next cycle and in_ready returns to 1.
- Assert rst mid-ciphertext (byte 4) → all outputs at reset values on the next cycle. A following full frame completes.
- With XTEA_LOADER_CHECKSUM_EN: correct checksum → job_ready. Checksum byte flipped (XOR 01) → err pulse, no job_ready, return to S_SYNC.
